output_buffer: RTL and testbench

- Memory-mapped output register bank that drives the board-level LEDs, the seven-segment displays and the LCD port from the core's load/store unit.
- It is the write-side counterpart of the switch input synchronizer: the core writes, the block registers the values and holds them stable on the pins.
- It supports byte-enabled writes and registered read-back, so firmware can do read-modify-write on output state.

---
 rtl/output_buffer.sv | 152 +++++++++++++++
 tb/tb_output_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// output_buffer
//   Memory-mapped output register bank driving the board LEDs, the eight
//   seven-segment digits and the LCD port. The core's load/store unit writes
//   and reads the registers. Pins are driven straight from the registers.
//
//   Register map (page = i_addr[15:12], offset i_addr[11:0] ignored):
//     0 LEDR   1 LEDG   2 HEX0-3 (byte n = HEXn)   3 HEX4-7   4 LCD
//     5..15 unmapped: o_err pulses; a read also returns 0 with o_rvalid.
//
//   Ports
//     i_clk, i_reset        clock, synchronous active-high reset
//     i_addr/i_wdata/i_bmask bus request, sampled only in strobe cycles
//     i_wen, i_ren          single-cycle strobes; each high cycle is one access
//     o_rdata, o_rvalid     registered read data and its one-cycle valid pulse
//     o_err                 one-cycle pulse on an unmapped in-region access
//     o_io_*                output pins
//
//   Bus protocol: there is no ready/backpressure. A strobe high on a rising
//   edge with an in-region address is accepted on that edge. The response
//   (o_rvalid, o_err) appears exactly one cycle later and lasts one cycle.
//   Accesses may follow each other on every cycle. Out-of-region accesses are
//   ignored entirely.
module output_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          LEDR_W    = 17,
  parameter int          LEDG_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic        i_wen,
  input  logic        i_ren,
  input  logic [3:0]  i_bmask,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_err,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  // Implemented-bit masks. Unimplemented bits are cleared on every write, so
  // they stay 0 on the pins and on read-back.
  localparam logic [31:0] LEDR_MASK = 32'((64'd1 << LEDR_W) - 64'd1);
  localparam logic [31:0] LEDG_MASK = 32'((64'd1 << LEDG_W) - 64'd1);
  localparam logic [31:0] HEX_MASK  = 32'h7F7F_7F7F;
  localparam logic [31:0] HEX_OFF   = 32'h7F7F_7F7F;

  localparam logic [3:0] IDX_LEDR = 4'd0;
  localparam logic [3:0] IDX_LEDG = 4'd1;
  localparam logic [3:0] IDX_HEXL = 4'd2;
  localparam logic [3:0] IDX_HEXH = 4'd3;
  localparam logic [3:0] IDX_LCD  = 4'd4;

  // HEX digits are kept packed as bus words with bit 7 of every byte held 0.
  logic [31:0] ledr;
  logic [31:0] ledg;
  logic [31:0] hex_lo;
  logic [31:0] hex_hi;
  logic [31:0] lcd;

  logic        hit;
  logic [3:0]  index;
  logic        mapped;
  logic        do_wr;
  logic        do_rd;
  logic [31:0] lane_mask;
  logic [31:0] read_word;

  // The page offset is deliberately ignored: every word of a page aliases.
  logic unused_offset;
  assign unused_offset = ^i_addr[11:0];

  assign hit       = (i_addr[31:16] == BASE_ADDR[31:16]);
  assign index     = i_addr[15:12];
  assign mapped    = (index <= IDX_LCD);
  assign do_wr     = hit && i_wen && mapped;
  assign do_rd     = hit && i_ren;
  assign lane_mask = {{8{i_bmask[3]}}, {8{i_bmask[2]}},
                      {8{i_bmask[1]}}, {8{i_bmask[0]}}};

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] keep_mask);
    return ((old_val & ~lane_mask) | (i_wdata & lane_mask)) & keep_mask;
  endfunction

  // Read mux sees the pre-write register values, which gives
  // read-before-write when both strobes hit the same register.
  always_comb begin
    read_word = 32'h0;
    case (index)
      IDX_LEDR: read_word = ledr;
      IDX_LEDG: read_word = ledg;
      IDX_HEXL: read_word = hex_lo;
      IDX_HEXH: read_word = hex_hi;
      IDX_LCD:  read_word = lcd;
      default:  read_word = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr     <= 32'h0;
      ledg     <= 32'h0;
      hex_lo   <= HEX_OFF;
      hex_hi   <= HEX_OFF;
      lcd      <= 32'h0;
      o_rdata  <= 32'h0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      if (do_wr) begin
        case (index)
          IDX_LEDR: ledr   <= merge(ledr, LEDR_MASK);
          IDX_LEDG: ledg   <= merge(ledg, LEDG_MASK);
          IDX_HEXL: hex_lo <= merge(hex_lo, HEX_MASK);
          IDX_HEXH: hex_hi <= merge(hex_hi, HEX_MASK);
          IDX_LCD:  lcd    <= merge(lcd, 32'hFFFF_FFFF);
          default:  ;
        endcase
      end
      // o_rdata holds its last value outside read-valid cycles.
      if (do_rd) begin
        o_rdata <= read_word;
      end
      o_rvalid <= do_rd;
      o_err    <= hit && (i_wen || i_ren) && !mapped;
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hex_lo[6:0];
  assign o_io_hex1 = hex_lo[14:8];
  assign o_io_hex2 = hex_lo[22:16];
  assign o_io_hex3 = hex_lo[30:24];
  assign o_io_hex4 = hex_hi[6:0];
  assign o_io_hex5 = hex_hi[14:8];
  assign o_io_hex6 = hex_hi[22:16];
  assign o_io_hex7 = hex_hi[30:24];

endmodule

// File: tb/tb_output_buffer.sv
// Testbench for output_buffer: scenario tasks driven from one initial block.
// Read expectations are pushed to exp_q when a read is issued and popped when
// o_rvalid is observed.
module tb_output_buffer;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_addr;
  logic        i_wen;
  logic        i_ren;
  logic [3:0]  i_bmask;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_err;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic [31:0] o_io_lcd;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          n_checks;
  int          n_pass;

  output_buffer dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_addr    (i_addr),
    .i_wen     (i_wen),
    .i_ren     (i_ren),
    .i_bmask   (i_bmask),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_rvalid  (o_rvalid),
    .o_err     (o_err),
    .o_io_ledr (o_io_ledr),
    .o_io_ledg (o_io_ledg),
    .o_io_hex0 (o_io_hex0),
    .o_io_hex1 (o_io_hex1),
    .o_io_hex2 (o_io_hex2),
    .o_io_hex3 (o_io_hex3),
    .o_io_hex4 (o_io_hex4),
    .o_io_hex5 (o_io_hex5),
    .o_io_hex6 (o_io_hex6),
    .o_io_hex7 (o_io_hex7),
    .o_io_lcd  (o_io_lcd)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- observation helpers ----------------
  function automatic logic [31:0] pins_hex_lo();
    return {1'b0, o_io_hex3, 1'b0, o_io_hex2, 1'b0, o_io_hex1, 1'b0, o_io_hex0};
  endfunction

  function automatic logic [31:0] pins_hex_hi();
    return {1'b0, o_io_hex7, 1'b0, o_io_hex6, 1'b0, o_io_hex5, 1'b0, o_io_hex4};
  endfunction

  // Reference lane merge used by the random scenario.
  function automatic logic [31:0] apply_lanes(input logic [31:0] old_val,
                                              input logic [31:0] d,
                                              input logic [3:0]  m);
    logic [31:0] r;
    r = old_val;
    for (int n = 0; n < 4; n++) begin
      if (m[n]) r[8*n +: 8] = d[8*n +: 8];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one bus cycle at the falling edge; return #1 after the rising
  // edge, where the response of this access is visible.
  task automatic bus_cycle(input logic wen, input logic ren,
                           input logic [31:0] addr, input logic [3:0] bmask,
                           input logic [31:0] wdata);
    @(negedge clk);
    i_wen   = wen;
    i_ren   = ren;
    i_addr  = addr;
    i_bmask = bmask;
    i_wdata = wdata;
    @(posedge clk);
    #1;
    i_wen = 1'b0;
    i_ren = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_io_ledr !== 32'h0 || o_io_ledg !== 32'h0 || o_io_lcd !== 32'h0)
      $display("FAIL reset_regs: ledr=%h ledg=%h lcd=%h required all 0", o_io_ledr, o_io_ledg, o_io_lcd);
    else n_pass++;
    n_checks++;
    if (pins_hex_lo() !== 32'h7F7F7F7F || pins_hex_hi() !== 32'h7F7F7F7F)
      $display("FAIL reset_hex: lo=%h hi=%h required 7f7f7f7f", pins_hex_lo(), pins_hex_hi());
    else n_pass++;
    n_checks++;
    if (o_rvalid !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL reset_resp: rvalid=%b err=%b rdata=%h required 0/0/0", o_rvalid, o_err, o_rdata);
    else n_pass++;
    @(negedge clk);
    i_reset = 1'b0;
    idle_cycle();
    exp_q.push_back(32'h7F7F7F7F);
    bus_cycle(1'b0, 1'b1, 32'h1000_2000, 4'h0, 32'h0);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp) $display("FAIL rd_hex_reset: got %h required %h", o_rdata, exp);
      else n_pass++;
    end else $display("FAIL rd_hex_reset: rvalid=%b required 1", o_rvalid);
  endtask

  task automatic test_ledr_write();
    bus_cycle(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'hFFFF_FFFF);
    n_checks++;
    if (o_io_ledr !== 32'h0001_FFFF) $display("FAIL ledr_pins: got %h required 0001ffff", o_io_ledr);
    else n_pass++;
    exp_q.push_back(32'h0001_FFFF);
    bus_cycle(1'b0, 1'b1, 32'h1000_0000, 4'h0, 32'h0);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp) $display("FAIL rd_ledr: got %h required %h", o_rdata, exp);
      else n_pass++;
    end else $display("FAIL rd_ledr: rvalid=%b required 1", o_rvalid);
    idle_cycle();
    n_checks++;
    if (o_rvalid !== 1'b0 || o_rdata !== 32'h0001_FFFF)
      $display("FAIL rvalid_pulse: rvalid=%b rdata=%h required 0 and held 0001ffff", o_rvalid, o_rdata);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    bus_cycle(1'b1, 1'b0, 32'h1000_3000, 4'b0101, 32'hABCD_1234);
    n_checks++;
    if (o_io_hex4 !== 7'h34 || o_io_hex5 !== 7'h7F || o_io_hex6 !== 7'h4D || o_io_hex7 !== 7'h7F)
      $display("FAIL hex_hi_lanes: got %h required 7f4d7f34", pins_hex_hi());
    else n_pass++;
    exp_q.push_back(32'h7F4D_7F34);
    bus_cycle(1'b0, 1'b1, 32'h1000_3000, 4'h0, 32'h0);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp) $display("FAIL rd_hex_hi: got %h required %h", o_rdata, exp);
      else n_pass++;
    end else $display("FAIL rd_hex_hi: rvalid=%b required 1", o_rvalid);
    // Bit 7 of each HEX byte is dropped.
    bus_cycle(1'b1, 1'b0, 32'h1000_2000, 4'hF, 32'h80FF_0102);
    exp_q.push_back(32'h007F_0102);
    bus_cycle(1'b0, 1'b1, 32'h1000_2000, 4'hF, 32'hFFFF_FFFF);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp) $display("FAIL rd_hex_lo_bit7: got %h required %h", o_rdata, exp);
      else n_pass++;
    end else $display("FAIL rd_hex_lo_bit7: rvalid=%b required 1", o_rvalid);
    // Empty byte mask changes nothing and raises no error.
    bus_cycle(1'b1, 1'b0, 32'h1000_3000, 4'b0000, 32'h0000_0000);
    n_checks++;
    if (pins_hex_hi() !== 32'h7F4D_7F34 || o_err !== 1'b0)
      $display("FAIL bmask_zero: hex_hi=%h err=%b required 7f4d7f34 and 0", pins_hex_hi(), o_err);
    else n_pass++;
  endtask

  task automatic test_rw_same_cycle();
    bus_cycle(1'b1, 1'b0, 32'h1000_4000, 4'hF, 32'h0000_0001);
    exp_q.push_back(32'h0000_0001);
    bus_cycle(1'b1, 1'b1, 32'h1000_4000, 4'hF, 32'hDEAD_BEEF);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp) $display("FAIL rd_before_wr: got %h required %h", o_rdata, exp);
      else n_pass++;
    end else $display("FAIL rd_before_wr: rvalid=%b required 1", o_rvalid);
    // Read through an aliased offset in the same page.
    exp_q.push_back(32'hDEAD_BEEF);
    bus_cycle(1'b0, 1'b1, 32'h1000_4FFC, 4'h0, 32'h0);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp || o_io_lcd !== 32'hDEAD_BEEF)
        $display("FAIL rd_lcd_alias: got %h pins %h required %h", o_rdata, o_io_lcd, exp);
      else n_pass++;
    end else $display("FAIL rd_lcd_alias: rvalid=%b required 1", o_rvalid);
  endtask

  task automatic test_unmapped();
    bus_cycle(1'b1, 1'b0, 32'h1000_7000, 4'hF, 32'hFFFF_FFFF);
    n_checks++;
    if (o_err !== 1'b1 || o_rvalid !== 1'b0)
      $display("FAIL unmapped_wr_err: err=%b rvalid=%b required 1/0", o_err, o_rvalid);
    else n_pass++;
    n_checks++;
    if (o_io_ledr !== 32'h0001_FFFF || o_io_ledg !== 32'h0 || o_io_lcd !== 32'hDEAD_BEEF ||
        pins_hex_lo() !== 32'h007F_0102 || pins_hex_hi() !== 32'h7F4D_7F34)
      $display("FAIL unmapped_wr_state: ledr=%h ledg=%h lcd=%h changed", o_io_ledr, o_io_ledg, o_io_lcd);
    else n_pass++;
    exp_q.push_back(32'h0);
    bus_cycle(1'b0, 1'b1, 32'h1000_7000, 4'h0, 32'h0);
    n_checks++;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (o_rdata !== exp || o_err !== 1'b1)
        $display("FAIL unmapped_rd: rdata=%h err=%b required %h and 1", o_rdata, o_err, exp);
      else n_pass++;
    end else $display("FAIL unmapped_rd: rvalid=%b required 1", o_rvalid);
    idle_cycle();
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL err_pulse: err=%b required 0", o_err);
    else n_pass++;
    // Outside the region: page 0 would be LEDR if the region match failed.
    bus_cycle(1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0000_0000);
    n_checks++;
    if (o_err !== 1'b0 || o_rvalid !== 1'b0 || o_io_ledr !== 32'h0001_FFFF)
      $display("FAIL out_region_wr: err=%b rvalid=%b ledr=%h required 0/0/0001ffff", o_err, o_rvalid, o_io_ledr);
    else n_pass++;
    bus_cycle(1'b0, 1'b1, 32'h2000_0000, 4'h0, 32'h0);
    n_checks++;
    if (o_err !== 1'b0 || o_rvalid !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL out_region_rd: err=%b rvalid=%b rdata=%h required 0/0/held 0", o_err, o_rvalid, o_rdata);
    else n_pass++;
  endtask

  // Consecutive-cycle write+read to LEDG with random data and lanes.
  task automatic test_back_to_back();
    logic [31:0] m_ledg;
    logic [31:0] d;
    logic [3:0]  m;
    m_ledg = 32'h0;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      exp_q.push_back(m_ledg);
      m_ledg = apply_lanes(m_ledg, d, m) & 32'h0000_00FF;
      bus_cycle(1'b1, 1'b1, 32'h1000_1000 | 32'($urandom_range(0, 4095)), m, d);
      n_checks++;
      if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (o_rdata !== exp || o_err !== 1'b0)
          $display("FAIL b2b_rd[%0d]: got %h err=%b required %h", i, o_rdata, o_err, exp);
        else n_pass++;
      end else $display("FAIL b2b_rd[%0d]: rvalid=%b required 1", i, o_rvalid);
      n_checks++;
      if (o_io_ledg !== m_ledg) $display("FAIL b2b_pins[%0d]: got %h required %h", i, o_io_ledg, m_ledg);
      else n_pass++;
    end
  endtask

  task automatic test_reset_with_write();
    bus_cycle(1'b1, 1'b0, 32'h1000_1000, 4'hF, 32'h0000_00FF);
    n_checks++;
    if (o_io_ledg !== 32'h0000_00FF) $display("FAIL ledg_pre: got %h required 000000ff", o_io_ledg);
    else n_pass++;
    @(negedge clk);
    i_reset = 1'b1;
    i_wen   = 1'b1;
    i_addr  = 32'h1000_1000;
    i_bmask = 4'hF;
    i_wdata = 32'h0000_000F;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_wen   = 1'b0;
    n_checks++;
    if (o_io_ledg !== 32'h0 || o_io_ledr !== 32'h0 || o_io_lcd !== 32'h0)
      $display("FAIL rst_wins_regs: ledg=%h ledr=%h lcd=%h required 0", o_io_ledg, o_io_ledr, o_io_lcd);
    else n_pass++;
    n_checks++;
    if (pins_hex_lo() !== 32'h7F7F7F7F || pins_hex_hi() !== 32'h7F7F7F7F)
      $display("FAIL rst_wins_hex: lo=%h hi=%h required 7f7f7f7f", pins_hex_lo(), pins_hex_hi());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_reset  = 1'b1;
    i_wen    = 1'b0;
    i_ren    = 1'b0;
    i_addr   = 32'h0;
    i_bmask  = 4'h0;
    i_wdata  = 32'h0;
    test_reset();
    test_ledr_write();
    test_byte_lanes();
    test_rw_same_cycle();
    test_unmapped();
    test_back_to_back();
    test_reset_with_write();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d reads never answered, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
